// File: rtl/data_mov_seq_if.sv
// rtl/data_mov_seq_if.sv - memory request/acknowledge bus between the sequencer and memory
//
// Signals:
//   mem_req    request, held until mem_ack or timeout   (master -> slave)
//   mem_we     1 = write, 0 = read                      (master -> slave)
//   mem_addr   byte address, stable while mem_req=1     (master -> slave)
//   mem_wdata  write data, stable while mem_req=1       (master -> slave)
//   mem_ack    acknowledge, meaningful only with mem_req (slave -> master)
//   mem_rdata  read data, valid in the mem_ack cycle    (slave -> master)

interface data_mov_seq_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/data_mov_seq.sv
// rtl/data_mov_seq.sv - multi-cycle sequencer for MV, LDW, STW, PUSH and POP
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start           launch instruction, sampled only in IDLE
//   opcode          LDW=00001 STW=00010 MV=00011 PUSH=10011 POP=10100
//   has_imm, imm    operand is {16'b0, imm} when has_imm=1, else src_val
//   src_val         register-file source operand
//   busy            high in every state except IDLE
//   done, err       one-cycle completion pulse; err qualifies done
//   mem             memory bus (master side)
//   reg_we          register-file write strobe
//   reg_wdata       register-file write data
//   rsp             architectural stack pointer

module data_mov_seq #(
   parameter logic [31:0] RSP_RESET   = 32'h0000_FFFC,
   parameter logic [31:0] STACK_STEP  = 32'd4,
   parameter int          MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4:0]            opcode,
   input  logic                  has_imm,
   input  logic [15:0]           imm,
   input  logic [31:0]           src_val,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   data_mov_seq_if.master        mem,
   output logic                  reg_we,
   output logic [31:0]           reg_wdata,
   output logic [31:0]           rsp
);

   localparam logic [4:0] OP_LDW  = 5'b00001;
   localparam logic [4:0] OP_STW  = 5'b00010;
   localparam logic [4:0] OP_MV   = 5'b00011;
   localparam logic [4:0] OP_PUSH = 5'b10011;
   localparam logic [4:0] OP_POP  = 5'b10100;

   localparam int            CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_WB   = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [4:0]        op_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [31:0]       wb_q;
   logic [31:0]       rsp_q;

   logic [31:0]       operand;
   logic              tmo_hit;

   assign operand = has_imm ? {16'b0, imm} : src_val;
   assign tmo_hit = (cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (opcode)
                  OP_MV:                           state_nxt = S_WB;
                  OP_LDW, OP_STW, OP_PUSH, OP_POP: state_nxt = S_MEM;
                  default:                         state_nxt = S_FIN;
               endcase
            end
         end
         S_MEM: begin
            // An ack in the final allowed cycle still wins over the timeout.
            if (mem.mem_ack) begin
               if (op_q == OP_LDW || op_q == OP_POP) begin
                  state_nxt = S_WB;
               end else begin
                  state_nxt = S_FIN;
               end
            end else if (tmo_hit) begin
               state_nxt = S_FIN;
            end
         end
         S_WB:    state_nxt = S_IDLE;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: everything needed for the transaction is captured at start,
   // so input changes while busy have no effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q    <= 5'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         we_q    <= 1'b0;
         wb_q    <= 32'b0;
         rsp_q   <= RSP_RESET;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= opcode;
                  cnt_q <= '0;
                  err_q <= 1'b0;
                  case (opcode)
                     OP_MV: begin
                        wb_q <= operand;
                     end
                     OP_LDW: begin
                        addr_q <= {16'b0, imm};
                        we_q   <= 1'b0;
                     end
                     OP_STW: begin
                        // STW always stores the register operand, even with has_imm set.
                        addr_q  <= {16'b0, imm};
                        we_q    <= 1'b1;
                        wdata_q <= src_val;
                     end
                     OP_PUSH: begin
                        // Pre-decrement: the slot below the current top.
                        addr_q  <= rsp_q - STACK_STEP;
                        we_q    <= 1'b1;
                        wdata_q <= operand;
                     end
                     OP_POP: begin
                        addr_q <= rsp_q;
                        we_q   <= 1'b0;
                     end
                     default: begin
                        err_q <= 1'b1;
                     end
                  endcase
               end
            end
            S_MEM: begin
               if (mem.mem_ack) begin
                  if (op_q == OP_PUSH) begin
                     rsp_q <= rsp_q - STACK_STEP;
                  end else if (op_q == OP_POP) begin
                     rsp_q <= rsp_q + STACK_STEP;
                  end
                  if (op_q == OP_LDW || op_q == OP_POP) begin
                     wb_q <= mem.mem_rdata;
                  end
               end else if (tmo_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_WB) || (state == S_FIN);
   assign err           = (state == S_FIN) && err_q;
   assign reg_we        = (state == S_WB);
   assign reg_wdata     = wb_q;
   assign rsp           = rsp_q;

   assign mem.mem_req   = (state == S_MEM);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mov_seq.sv
// tb/tb_data_mov_seq.sv - directed self-checking bench for data_mov_seq
//
// Ports of the DUT are all driven/observed here; the memory side is a
// hand-driven data_mov_seq_if instance.

module tb_data_mov_seq;

   localparam logic [4:0] OP_LDW  = 5'b00001;
   localparam logic [4:0] OP_STW  = 5'b00010;
   localparam logic [4:0] OP_MV   = 5'b00011;
   localparam logic [4:0] OP_PUSH = 5'b10011;
   localparam logic [4:0] OP_POP  = 5'b10100;
   localparam logic [4:0] OP_BAD  = 5'b11111;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  opcode;
   logic        has_imm;
   logic [15:0] imm;
   logic [31:0] src_val;
   logic        busy;
   logic        done;
   logic        err;
   logic        reg_we;
   logic [31:0] reg_wdata;
   logic [31:0] rsp;

   int n_tests = 0;
   int n_fail  = 0;

   data_mov_seq_if bus ();

   data_mov_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .opcode    (opcode),
      .has_imm   (has_imm),
      .imm       (imm),
      .src_val   (src_val),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem       (bus.master),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .rsp       (rsp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int req_cycles;
      int saw_we;
      int done_cnt;
      int cyc;

      rst           = 1'b1;
      start         = 1'b0;
      opcode        = 5'b0;
      has_imm       = 1'b0;
      imm           = 16'h0;
      src_val       = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;

      // Reset state
      tick();
      tick();
      check("rst_busy",      busy,          0);
      check("rst_done",      done,          0);
      check("rst_err",       err,           0);
      check("rst_req",       bus.mem_req,   0);
      check("rst_we",        bus.mem_we,    0);
      check("rst_addr",      bus.mem_addr,  0);
      check("rst_wdata",     bus.mem_wdata, 0);
      check("rst_reg_we",    reg_we,        0);
      check("rst_reg_wdata", reg_wdata,     0);
      check("rst_rsp",       rsp,           32'h0000_FFFC);
      rst = 1'b0;
      tick();

      // MV imm: done at T+1
      opcode = OP_MV; has_imm = 1'b1; imm = 16'h1234; start = 1'b1;
      tick();
      start = 1'b0; imm = 16'hFFFF;
      check("mv_reg_we",    reg_we,    1);
      check("mv_reg_wdata", reg_wdata, 32'h0000_1234);
      check("mv_done",      done,      1);
      check("mv_err",       err,       0);
      check("mv_req",       bus.mem_req, 0);
      tick();
      check("mv_busy_after", busy, 0);
      check("mv_done_after", done, 0);

      // PUSH register operand, ack in T+3
      opcode = OP_PUSH; has_imm = 1'b0; src_val = 32'hDEAD_BEEF; start = 1'b1;
      tick();
      start = 1'b0; src_val = 32'h0;
      check("push_req_t1",   bus.mem_req,   1);
      check("push_addr",     bus.mem_addr,  32'h0000_FFF8);
      check("push_we",       bus.mem_we,    1);
      check("push_wdata",    bus.mem_wdata, 32'hDEAD_BEEF);
      check("push_rsp_wait", rsp,           32'h0000_FFFC);
      tick();
      check("push_req_t2",   bus.mem_req,   1);
      check("push_done_t2",  done,          0);
      tick();
      check("push_req_t3",   bus.mem_req,   1);
      check("push_addr_t3",  bus.mem_addr,  32'h0000_FFF8);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("push_req_t4",   bus.mem_req,   0);
      check("push_done",     done,          1);
      check("push_err",      err,           0);
      check("push_reg_we",   reg_we,        0);
      check("push_rsp",      rsp,           32'h0000_FFF8);
      tick();
      check("push_busy_after", busy, 0);

      // POP with ack in first request cycle
      opcode = OP_POP; start = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
      tick();
      start = 1'b0;
      check("pop_req",  bus.mem_req,  1);
      check("pop_addr", bus.mem_addr, 32'h0000_FFF8);
      check("pop_we",   bus.mem_we,   0);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      check("pop_req_after", bus.mem_req, 0);
      check("pop_reg_we",    reg_we,      1);
      check("pop_reg_wdata", reg_wdata,   32'hCAFE_0001);
      check("pop_done",      done,        1);
      check("pop_err",       err,         0);
      check("pop_rsp",       rsp,         32'h0000_FFFC);
      tick();

      // LDW with no ack: 15 request cycles then error
      opcode = OP_LDW; has_imm = 1'b0; imm = 16'h0040; start = 1'b1;
      tick();
      start = 1'b0;
      check("ldw_addr", bus.mem_addr, 32'h0000_0040);
      check("ldw_we",   bus.mem_we,   0);
      req_cycles = 0;
      saw_we     = 0;
      cyc        = 0;
      while (!done && cyc < 40) begin
         if (bus.mem_req) req_cycles++;
         if (reg_we) saw_we++;
         tick();
         cyc++;
      end
      check("ldw_tmo_bound", (cyc < 40) ? 1 : 0, 1);
      check("ldw_req_cycles", req_cycles,  15);
      check("ldw_tmo_done",   done,        1);
      check("ldw_tmo_err",    err,         1);
      check("ldw_tmo_req",    bus.mem_req, 0);
      check("ldw_tmo_regwe",  saw_we + (reg_we ? 1 : 0), 0);
      check("ldw_tmo_rsp",    rsp,         32'h0000_FFFC);
      tick();
      // Late ack while idle is ignored
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
      tick();
      bus.mem_ack = 1'b0;
      check("late_ack_busy", busy,   0);
      check("late_ack_done", done,   0);
      check("late_ack_rsp",  rsp,    32'h0000_FFFC);
      check("late_ack_we",   reg_we, 0);

      // Illegal opcode
      opcode = OP_BAD; start = 1'b1;
      tick();
      start = 1'b0;
      check("bad_done", done,        1);
      check("bad_err",  err,         1);
      check("bad_req",  bus.mem_req, 0);
      check("bad_regwe", reg_we,     0);
      tick();
      check("bad_busy_after", busy,  0);
      check("bad_req_after",  bus.mem_req, 0);

      // STW with has_imm=1 still stores src_val; start during MEM ignored
      opcode = OP_STW; has_imm = 1'b1; imm = 16'h0100; src_val = 32'h55AA_55AA; start = 1'b1;
      tick();
      check("stw_addr",  bus.mem_addr,  32'h0000_0100);
      check("stw_we",    bus.mem_we,    1);
      check("stw_wdata", bus.mem_wdata, 32'h55AA_55AA);
      opcode = OP_MV; imm = 16'h0BAD; src_val = 32'h0;
      tick();
      start = 1'b0;
      check("stw_busy_t2", busy,        1);
      check("stw_req_t2",  bus.mem_req, 1);
      check("stw_done_t2", done,        0);
      check("stw_addr_t2", bus.mem_addr, 32'h0000_0100);
      done_cnt = 0;
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("stw_done", done,   1);
      check("stw_err",  err,    0);
      check("stw_regwe", reg_we, 0);
      check("stw_rsp",  rsp,    32'h0000_FFFC);
      if (done) done_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("stw_single_done", done_cnt, 1);

      // PUSH immediate completing, then reset during a second PUSH
      opcode = OP_PUSH; has_imm = 1'b1; imm = 16'h0077; start = 1'b1;
      tick();
      start = 1'b0;
      check("pushi_wdata", bus.mem_wdata, 32'h0000_0077);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("pushi_rsp", rsp, 32'h0000_FFF8);
      tick();
      opcode = OP_PUSH; has_imm = 1'b0; src_val = 32'h0000_ABCD; start = 1'b1;
      tick();
      start = 1'b0;
      check("push2_addr", bus.mem_addr, 32'h0000_FFF4);
      check("push2_req",  bus.mem_req,  1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_req",  bus.mem_req, 0);
      check("rstmid_busy", busy,        0);
      check("rstmid_rsp",  rsp,         32'h0000_FFFC);
      check("rstmid_done", done,        0);
      tick();
      check("rstmid_done2", done,   0);
      check("rstmid_regwe", reg_we, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mov_seq.md
Name: data_mov_seq

Overview:
Multi-cycle sequencer for the data-movement instruction class: MV, LDW, STW, PUSH and POP. It latches one decoded instruction and drives the memory request/acknowledge handshake. It performs the register-file writeback and owns the architectural stack pointer (rsp). It sits between the decode stage and the memory/register-file ports and reports completion to the core controller with a one-cycle done pulse.

Parameters:
RSP_RESET, 32'h0000_FFFC, value loaded into rsp on reset
STACK_STEP, 4, byte decrement/increment applied to rsp by PUSH/POP
MEM_TIMEOUT, 15, max cycles mem_req stays high without mem_ack before abort (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  launch instruction; sampled only in IDLE
opcode  in  5  LDW=00001, STW=00010, MV=00011, PUSH=10011, POP=10100
has_imm  in  1  source is imm (MV, PUSH) instead of src_val
imm  in  16  immediate / absolute address; zero-extended to 32
src_val  in  32  register-file source operand
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: 1 = illegal opcode or memory timeout
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  1 = write (STW, PUSH), 0 = read
mem_addr  out  32  memory byte address
mem_wdata  out  32  write data
mem_ack  in  1  memory acknowledge; meaningful only while mem_req=1
mem_rdata  in  32  read data, valid in the mem_ack cycle
reg_we  out  1  register-file write strobe, one cycle
reg_wdata  out  32  register-file write data
rsp  out  32  current stack pointer

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; rsp = RSP_RESET.
  - busy, done, err, mem_req, mem_we, reg_we = 0; mem_addr, mem_wdata, reg_wdata = 0.
  - Reset mid-transaction aborts the transaction: no done, no writeback, rsp is reloaded.
- Operand source: operand = has_imm ? {16'b0, imm} : src_val. All inputs are latched at start; later input changes are ignored until the next IDLE.
- States: IDLE, MEM, WB, FIN.
- IDLE with start=1 (cycle T):
  - MV -> WB.
  - LDW, STW, PUSH, POP -> MEM.
  - Any other opcode -> FIN with err=1.
  - start while busy=1 is ignored; no queueing.
- MEM: mem_req=1 from T+1; mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - LDW: addr = {16'b0, imm}, we=0.
  - STW: addr = {16'b0, imm}, we=1, wdata = src_val.
  - PUSH: addr = rsp - STACK_STEP, we=1, wdata = operand.
  - POP: addr = rsp, we=0.
  - An ack in the first request cycle is valid (minimum one MEM cycle).
- On mem_ack:
  - mem_req drops the next cycle.
  - PUSH: rsp <= rsp - STACK_STEP. POP: rsp <= rsp + STACK_STEP. Arithmetic is modulo 2^32; wrap is silent.
  - LDW, POP: capture mem_rdata, then go to WB.
  - STW, PUSH: go to FIN.
- Timeout: a counter clears on entry to MEM. If MEM_TIMEOUT consecutive MEM cycles pass without ack:
  - mem_req drops and the state goes to FIN with err=1.
  - rsp is unchanged and there is no reg_we.
  - A late mem_ack while mem_req=0 is ignored.
- WB (one cycle): reg_we=1, done=1, err=0.
  - reg_wdata = operand for MV, captured rdata for LDW/POP.
  - Next state IDLE.
- FIN (one cycle): done=1, err as set; next state IDLE.
- Latency:
  - MV: done at T+1.
  - Memory op with ack in cycle T+k (k>=1): done at T+k+1.
  - Illegal opcode: done at T+1.
- A new start is accepted in the cycle after done (back-to-back issue allowed).

Test Plan:
- Reset, then MV has_imm=1 imm=16'h1234 at T -> at T+1 reg_we=1, reg_wdata=32'h0000_1234, done=1, err=0; busy=0 at T+2.
- PUSH has_imm=0 src_val=32'hDEAD_BEEF, ack after 3 cycles -> mem_req high T+1..T+3, mem_addr=32'h0000_FFF8, mem_we=1, wdata=32'hDEAD_BEEF; rsp=32'h0000_FFF8 after ack; done at T+4.
- POP after that PUSH with mem_rdata=32'hCAFE_0001, ack on the first request cycle -> mem_addr=32'h0000_FFF8, we=0; rsp returns to 32'h0000_FFFC; reg_we=1, reg_wdata=32'hCAFE_0001.
- LDW imm=16'h0040, mem_ack never asserted -> mem_req high exactly 15 cycles, then done=1, err=1, reg_we never asserted, rsp unchanged.
- opcode=5'b11111 -> done=1, err=1 at T+1, mem_req=0 throughout; start pulsed during a pending STW is ignored (one done only).
- rst asserted while PUSH is waiting in MEM -> next cycle mem_req=0, busy=0, rsp=32'h0000_FFFC, no done pulse.
